// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift-register sequencer:
// command opcodes and the sequencer FSM state.
package usr_pkg;

    // Command opcodes as they appear on cmd_op.
    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_ROTL  = 2'd1,
        OP_ROTR  = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    // Sequencer states; the fourth encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the two rotate opcodes, which take their step count from the command.
    function automatic logic is_rotate(input op_t op);
        return (op == OP_ROTL) || (op == OP_ROTR);
    endfunction

endpackage

// File: rtl/usr_core.sv
// WIDTH-bit universal register: parallel load or one-bit rotate per cycle.
// Priority is reset, then load, then enable (left wins over right).
module usr_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic [WIDTH-1:0] q
);

    // Register update: load beats rotate; nothing changes when both are low.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would race other sequential blocks.
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (enable) begin
            if (shift_left) begin
                q <= {q[WIDTH-2:0], q[WIDTH-1]};
            end else if (shift_right) begin
                q <= {q[0], q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer around usr_core. Accepts one command in IDLE,
// steps the core in EXEC (one step per cycle), and presents the result in
// DONE until the consumer takes it.
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] done_q,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] steps;

    logic             core_load;
    logic [WIDTH-1:0] core_data;
    logic             core_enable;
    logic             core_left;
    logic             core_right;

    op_t              cmd_op_e;
    assign cmd_op_e = op_t'(cmd_op);

    // FSM, command latches, step counter and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_r       <= OP_LOAD;
            data_r     <= '0;
            steps      <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r      <= cmd_op_e;
                        data_r    <= cmd_data;
                        steps     <= is_rotate(cmd_op_e) ? cmd_count : CNT_W'(1);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        // A zero-length rotate has nothing to execute.
                        if (is_rotate(cmd_op_e) && (cmd_count == '0)) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    steps <= steps - CNT_W'(1);
                    // This edge performs the last step.
                    if (steps <= CNT_W'(1)) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state      <= IDLE;
                        done_valid <= 1'b0;
                        busy       <= 1'b0;
                        cmd_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    done_valid <= 1'b0;
                    busy       <= 1'b0;
                    cmd_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Core controls, decoded from registered state and latched command only.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        core_load   = 1'b0;
        core_data   = data_r;
        core_enable = 1'b0;
        core_left   = 1'b0;
        core_right  = 1'b0;
        if (state == EXEC) begin
            case (op_r)
                OP_LOAD:  core_load = 1'b1;
                OP_CLEAR: begin
                    core_load = 1'b1;
                    core_data = '0;
                end
                OP_ROTL: begin
                    core_enable = 1'b1;
                    core_left   = 1'b1;
                end
                OP_ROTR: begin
                    core_enable = 1'b1;
                    core_right  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    usr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (core_load),
        .load_data  (core_data),
        .enable     (core_enable),
        .shift_left (core_left),
        .shift_right(core_right),
        .q          (q)
    );

    // q holds outside EXEC, so in DONE it is the completion value.
    assign done_q = q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer: directed scenarios plus
// randomized commands checked against an arithmetic rotate model.
module tb_usr_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    localparam logic [1:0] C_LOAD  = 2'd0;
    localparam logic [1:0] C_ROTL  = 2'd1;
    localparam logic [1:0] C_ROTR  = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] done_q;
    logic [WIDTH-1:0] q;
    logic             busy;

    int vectors = 0;
    int errors  = 0;
    logic [WIDTH-1:0] exp_q = '0;

    always #5 clk = ~clk;

    usr_shift_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .done_valid(done_valid),
        .done_ready(done_ready),
        .done_q    (done_q),
        .q         (q),
        .busy      (busy)
    );

    // Reference: rotate by n positions using modular arithmetic on the value.
    function automatic logic [WIDTH-1:0] ref_rot(input logic [WIDTH-1:0] v, input int n, input bit left);
        int k;
        int val;
        int res;
        k   = n % WIDTH;
        val = int'(v);
        if (!left) k = (WIDTH - k) % WIDTH;
        res = (val * (1 << k)) % (1 << WIDTH) + (val / (1 << (WIDTH - k))) % (1 << WIDTH);
        if (k == 0) res = val;
        return res[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op, input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] d, input int n);
        case (op)
            C_LOAD:  return d;
            C_CLEAR: return '0;
            C_ROTL:  return ref_rot(cur, n, 1'b1);
            default: return ref_rot(cur, n, 1'b0);
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input int n);
        if (op == C_LOAD || op == C_CLEAR) return 1;
        return n;
    endfunction

    // Issue one command, time its completion, hold the result for 'hold'
    // cycles (optionally poking cmd_valid), then consume it.
    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] d, input int n,
                           input int hold, input bit poke, input string tag);
        int lat;
        int wait_cnt;
        logic [WIDTH-1:0] exp_res;
        exp_res = ref_result(op, exp_q, d, n);

        wait_cnt = 0;
        while (cmd_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready_timeout got=%b want=1", tag, cmd_ready);
            return;
        end

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = CNT_W'(n);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = WIDTH'($urandom);
        cmd_count = CNT_W'($urandom);

        lat = 0;
        while (1) begin
            @(negedge clk);
            if (done_valid === 1'b1 || lat > 40) break;
            lat++;
        end
        vectors++;
        if (lat !== ref_latency(op, n)) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d", tag, lat, ref_latency(op, n));
        end
        vectors++;
        if (done_valid !== 1'b1 || done_q !== exp_res || q !== exp_res || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s result done_valid=%b done_q=%b q=%b busy=%b want done_q=q=%b",
                     tag, done_valid, done_q, q, busy, exp_res);
        end

        for (int i = 0; i < hold; i++) begin
            done_ready = 1'b0;
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_op    = C_LOAD;
                cmd_data  = ~exp_res;
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (done_valid !== 1'b1 || done_q !== exp_res || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d done_valid=%b done_q=%b cmd_ready=%b want 1/%b/0",
                         tag, i, done_valid, done_q, cmd_ready, exp_res);
            end
        end
        cmd_valid = 1'b0;

        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (done_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || q !== exp_res) begin
            errors++;
            $display("FAIL %s release done_valid=%b cmd_ready=%b busy=%b q=%b want 0/1/0/%b",
                     tag, done_valid, cmd_ready, busy, q, exp_res);
        end
        exp_q = exp_res;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = C_LOAD;
        cmd_data   = '0;
        cmd_count  = '0;
        done_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (q !== '0 || cmd_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 || done_q !== '0) begin
                errors++;
                $display("FAIL reset_idle%0d q=%b cmd_ready=%b done_valid=%b busy=%b want 0000/1/0/0",
                         i, q, cmd_ready, done_valid, busy);
            end
        end
        exp_q = '0;
    endtask

    task automatic test_load_clear();
        run_cmd(C_LOAD, 4'b1011, 0, 0, 1'b0, "load_1011");
        run_cmd(C_CLEAR, 4'b1111, 5, 0, 1'b0, "clear");
    endtask

    task automatic test_rotate();
        run_cmd(C_LOAD, 4'b1011, 0, 0, 1'b0, "load_a");
        run_cmd(C_ROTL, 4'b0000, 1, 0, 1'b0, "rotl1");
        run_cmd(C_LOAD, 4'b1011, 0, 0, 1'b0, "load_b");
        run_cmd(C_ROTR, 4'b0000, 2, 0, 1'b0, "rotr2");
        run_cmd(C_LOAD, 4'b1011, 0, 0, 1'b0, "load_c");
        run_cmd(C_ROTL, 4'b0000, 4, 0, 1'b0, "rotl4_wrap");
        run_cmd(C_ROTR, 4'b0101, 0, 0, 1'b0, "rotr0");
        run_cmd(C_ROTR, 4'b0000, 7, 0, 1'b0, "rotr7");
    endtask

    task automatic test_backpressure();
        run_cmd(C_ROTL, 4'b0000, 3, 3, 1'b1, "backpressure");
        run_cmd(C_ROTR, 4'b0000, 1, 0, 1'b0, "after_poke");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom), WIDTH'($urandom), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 2)), 1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_abort();
        run_cmd(C_LOAD, 4'b1011, 0, 0, 1'b0, "abort_load");
        cmd_valid = 1'b1;
        cmd_op    = C_ROTL;
        cmd_data  = '0;
        cmd_count = CNT_W'(5);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (q !== '0 || done_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate q=%b done_valid=%b cmd_ready=%b busy=%b want 0000/0/1/0",
                     q, done_valid, cmd_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (q !== '0 || done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL abort_after%0d q=%b done_valid=%b cmd_ready=%b want 0000/0/1",
                         i, q, done_valid, cmd_ready);
            end
        end
        exp_q = '0;
        run_cmd(C_ROTL, 4'b0000, 2, 0, 1'b0, "post_abort");
    endtask

    initial begin
        test_reset();
        test_load_clear();
        test_rotate();
        test_backpressure();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
